csm_controller: RTL and testbench

Shared-memory responder for the two-processor CSM system. Accepts hold, release, read and write transactions from processor A and processor B over their per-processor enable/rw/AD handshakes. Serialises both processors onto one single-ported memory and one lock-ownership register, and returns ack, error code and read data per processor. It sits at the memory end of the CSM bus, directly opposite the processor-side drivers.

---
 rtl/csm_pkg.sv | 23 ++
 rtl/csm_port_fsm.sv | 74 +++++++
 rtl/csm_controller.sv | 129 ++++++++++++
 tb/tb_csm_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/csm_pkg.sv
// Shared types and constants for the CSM shared-memory responder.
package csm_pkg;

  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_LOCKED    = 2'b01;
  localparam logic [1:0] ERR_NOT_OWNER = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL   = 2'b11;

  typedef enum logic [1:0] {IDLE, WDATA, REQ, DONE} port_state_t;
  typedef enum logic [1:0] {NONE, OWN_A, OWN_B} owner_t;
  typedef enum logic [2:0] {OP_ILLEGAL, OP_HOLD, OP_RELEASE, OP_WRITE, OP_READ} op_t;
  typedef enum logic {GNT_A, GNT_B} side_t;

  // Priority: illegal > hold > release > write > read
  function automatic op_t decode_op(input logic rw, input logic hold, input logic rel);
    if (hold && rel)  return OP_ILLEGAL;
    else if (hold)    return OP_HOLD;
    else if (rel)     return OP_RELEASE;
    else if (rw)      return OP_WRITE;
    else              return OP_READ;
  endfunction

endpackage

// File: rtl/csm_port_fsm.sv
// Per-processor handshake FSM: latches the request, waits for a grant and
// registers ack/err/read data for the processor.
module csm_port_fsm
  import csm_pkg::*;
#(
  parameter int DATABITS = 8,
  parameter int ERRBITS  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATABITS-1:0] in_ad,
  input  logic                rw,
  input  logic                enable,
  input  logic                hold,
  input  logic                rel,
  input  logic                grant,
  input  logic [ERRBITS-1:0]  res_err,
  input  logic [DATABITS-1:0] res_data,
  output logic                req,
  output op_t                 op,
  output logic [DATABITS-1:0] addr,
  output logic [DATABITS-1:0] wdata,
  output logic                ack,
  output logic [ERRBITS-1:0]  err,
  output logic [DATABITS-1:0] out_data
);

  port_state_t state;

  assign req = (state == REQ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op       <= OP_READ;
      addr     <= '0;
      wdata    <= '0;
      ack      <= 1'b0;
      err      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b1;
          err <= '0;
          if (enable) begin
            addr  <= in_ad;
            op    <= decode_op(rw, hold, rel);
            ack   <= 1'b0;
            state <= (decode_op(rw, hold, rel) == OP_WRITE) ? WDATA : REQ;
          end
        end
        WDATA: begin
          wdata <= in_ad;
          state <= REQ;
        end
        REQ: begin
          if (grant) begin
            ack      <= 1'b1;
            err      <= res_err;
            out_data <= res_data;
            state    <= DONE;
          end
        end
        default: begin
          ack   <= 1'b1;
          err   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/csm_controller.sv
// CSM shared-memory responder: memory, round-robin arbiter and lock owner.
// Optional lock auto-release is enabled with `define CSM_LOCK_TIMEOUT_EN.
module csm_controller
  import csm_pkg::*;
#(
  parameter int DATABITS     = 8,
  parameter int ERRBITS      = 2,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATABITS-1:0] A_in_AD,
  input  logic                A_rw,
  input  logic                A_enable,
  input  logic                A_hold,
  input  logic                A_release,
  output logic                A_ack,
  output logic [ERRBITS-1:0]  A_err,
  output logic [DATABITS-1:0] A_out_data,
  input  logic [DATABITS-1:0] B_in_AD,
  input  logic                B_rw,
  input  logic                B_enable,
  input  logic                B_hold,
  input  logic                B_release,
  output logic                B_ack,
  output logic [ERRBITS-1:0]  B_err,
  output logic [DATABITS-1:0] B_out_data
);

  logic [DATABITS-1:0] mem [0:(1<<DATABITS)-1];

  logic                a_req, b_req, grant_a, grant_b;
  op_t                 a_op, b_op, op_s;
  logic [DATABITS-1:0] a_addr, b_addr, a_wdata, b_wdata, addr_s, wdata_s;
  logic [ERRBITS-1:0]  res_err;
  logic [DATABITS-1:0] res_data;
  owner_t              owner, owner_nx, self_s, other_s;
  side_t               last_grant;
  logic                mem_we;

  csm_port_fsm #(.DATABITS(DATABITS), .ERRBITS(ERRBITS)) u_port_a (
    .clk(clk), .reset(reset), .in_ad(A_in_AD), .rw(A_rw), .enable(A_enable),
    .hold(A_hold), .rel(A_release), .grant(grant_a), .res_err(res_err),
    .res_data(res_data), .req(a_req), .op(a_op), .addr(a_addr), .wdata(a_wdata),
    .ack(A_ack), .err(A_err), .out_data(A_out_data)
  );

  csm_port_fsm #(.DATABITS(DATABITS), .ERRBITS(ERRBITS)) u_port_b (
    .clk(clk), .reset(reset), .in_ad(B_in_AD), .rw(B_rw), .enable(B_enable),
    .hold(B_hold), .rel(B_release), .grant(grant_b), .res_err(res_err),
    .res_data(res_data), .req(b_req), .op(b_op), .addr(b_addr), .wdata(b_wdata),
    .ack(B_ack), .err(B_err), .out_data(B_out_data)
  );

  // Grants are suppressed during reset so an aborted write never lands.
  assign grant_a = ~reset & a_req & (~b_req | (last_grant == GNT_B));
  assign grant_b = ~reset & b_req & (~a_req | (last_grant == GNT_A));

  assign op_s    = grant_a ? a_op    : b_op;
  assign addr_s  = grant_a ? a_addr  : b_addr;
  assign wdata_s = grant_a ? a_wdata : b_wdata;
  assign self_s  = grant_a ? OWN_A   : OWN_B;
  assign other_s = grant_a ? OWN_B   : OWN_A;

  always_comb begin
    res_err  = '0;
    res_data = '0;
    owner_nx = owner;
    mem_we   = 1'b0;
    if (grant_a || grant_b) begin
      case (op_s)
        OP_ILLEGAL: res_err = ERRBITS'(ERR_ILLEGAL);
        OP_HOLD: begin
          if (owner == NONE || owner == self_s) owner_nx = self_s;
          else                                  res_err  = ERRBITS'(ERR_LOCKED);
        end
        OP_RELEASE: begin
          if (owner == self_s) owner_nx = NONE;
          else                 res_err  = ERRBITS'(ERR_NOT_OWNER);
        end
        default: begin
          if (owner == other_s)      res_err  = ERRBITS'(ERR_LOCKED);
          else if (op_s == OP_WRITE) mem_we   = 1'b1;
          else                       res_data = mem[addr_s];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_s] <= wdata_s;
  end

`ifdef CSM_LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             owner_grant;

  assign owner_grant = (grant_a && owner == OWN_A) || (grant_b && owner == OWN_B);
`endif

  // last_grant moves only on contested cycles, so collisions alternate winners.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= NONE;
      last_grant <= GNT_B;
`ifdef CSM_LOCK_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      if (a_req && b_req) last_grant <= grant_a ? GNT_A : GNT_B;
`ifdef CSM_LOCK_TIMEOUT_EN
      if (owner == NONE || owner_grant) begin
        tmo_cnt <= '0;
        owner   <= owner_nx;
      end else if (tmo_cnt == CNT_W'(LOCK_TIMEOUT)) begin
        tmo_cnt <= '0;
        owner   <= NONE;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
        owner   <= owner_nx;
      end
`else
      owner <= owner_nx;
`endif
    end
  end

endmodule

// File: tb/tb_csm_controller.sv
// Directed self-checking bench for csm_controller (table of transactions
// plus hand-written collision, reset-abort and lock-timeout sequences).
module tb_csm_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] A_in_AD, B_in_AD;
  logic       A_rw, A_enable, A_hold, A_release;
  logic       B_rw, B_enable, B_hold, B_release;
  logic       A_ack, B_ack;
  logic [1:0] A_err, B_err;
  logic [7:0] A_out_data, B_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  csm_controller #(.DATABITS(8), .ERRBITS(2), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .A_in_AD(A_in_AD), .A_rw(A_rw), .A_enable(A_enable), .A_hold(A_hold),
    .A_release(A_release), .A_ack(A_ack), .A_err(A_err), .A_out_data(A_out_data),
    .B_in_AD(B_in_AD), .B_rw(B_rw), .B_enable(B_enable), .B_hold(B_hold),
    .B_release(B_release), .B_ack(B_ack), .B_err(B_err), .B_out_data(B_out_data)
  );

  typedef struct {
    bit         pb;
    bit         rw, hd, rl;
    logic [7:0] addr, data;
    logic [1:0] err;
    bit         chk_data;
    logic [7:0] rdata;
    int         low;
  } vec_t;

  vec_t vt[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit pb, input bit en, input bit rw, input bit hd,
                       input bit rl, input logic [7:0] ad);
    if (!pb) begin
      A_enable = en; A_rw = rw; A_hold = hd; A_release = rl; A_in_AD = ad;
    end else begin
      B_enable = en; B_rw = rw; B_hold = hd; B_release = rl; B_in_AD = ad;
    end
  endtask

  function automatic logic get_ack(input bit pb);
    return pb ? B_ack : A_ack;
  endfunction

  task automatic run_txn(input bit pb, input bit rw, input bit hd, input bit rl,
                         input logic [7:0] addr, input logic [7:0] data,
                         output logic [1:0] err, output logic [7:0] rd, output int low);
    drive(pb, 1'b1, rw, hd, rl, addr);
    @(posedge clk); #1;
    drive(pb, 1'b0, 1'b0, 1'b0, 1'b0, data);
    low = 0;
    while (get_ack(pb) == 1'b0 && low < 20) begin
      low++;
      @(posedge clk); #1;
    end
    err = pb ? B_err : A_err;
    rd  = pb ? B_out_data : A_out_data;
    @(posedge clk); #1;
    check("idle err", {30'd0, pb ? B_err : A_err}, 32'd0);
  endtask

  function automatic vec_t mk(input bit pb, input bit rw, input bit hd, input bit rl,
                              input logic [7:0] addr, input logic [7:0] data,
                              input logic [1:0] err, input bit chk,
                              input logic [7:0] rdata, input int low);
    vec_t v;
    v.pb = pb; v.rw = rw; v.hd = hd; v.rl = rl; v.addr = addr; v.data = data;
    v.err = err; v.chk_data = chk; v.rdata = rdata; v.low = low;
    return v;
  endfunction

  logic [1:0] e;
  logic [7:0] d;
  int         lw;

  initial begin
    // Rows alternate A/B so a held lock never idles long enough to time out.
    vt[0]  = mk(0, 1, 0, 0, 8'h10, 8'h5A, 2'b00, 0, 8'h00, 2);
    vt[1]  = mk(1, 0, 0, 0, 8'h10, 8'h00, 2'b00, 1, 8'h5A, 1);
    vt[2]  = mk(0, 1, 0, 0, 8'h20, 8'hC3, 2'b00, 0, 8'h00, 2);
    vt[3]  = mk(0, 0, 1, 0, 8'h00, 8'h00, 2'b00, 0, 8'h00, 1);
    vt[4]  = mk(1, 1, 0, 0, 8'h20, 8'h33, 2'b01, 0, 8'h00, 2);
    vt[5]  = mk(0, 0, 0, 0, 8'h20, 8'h00, 2'b00, 1, 8'hC3, 1);
    vt[6]  = mk(1, 0, 0, 0, 8'h20, 8'h00, 2'b01, 1, 8'h00, 1);
    vt[7]  = mk(0, 1, 1, 1, 8'h20, 8'hFF, 2'b11, 0, 8'h00, 1);
    vt[8]  = mk(1, 0, 0, 1, 8'h00, 8'h00, 2'b10, 0, 8'h00, 1);
    vt[9]  = mk(0, 0, 0, 0, 8'h10, 8'h00, 2'b00, 1, 8'h5A, 1);
    vt[10] = mk(1, 1, 0, 0, 8'h20, 8'h33, 2'b01, 0, 8'h00, 2);
    vt[11] = mk(0, 0, 0, 1, 8'h00, 8'h00, 2'b00, 0, 8'h00, 1);
    vt[12] = mk(1, 1, 0, 0, 8'h20, 8'h33, 2'b00, 0, 8'h00, 2);
    vt[13] = mk(0, 0, 0, 0, 8'h20, 8'h00, 2'b00, 1, 8'h33, 1);
    vt[14] = mk(0, 0, 0, 1, 8'h00, 8'h00, 2'b10, 0, 8'h00, 1);
    vt[15] = mk(1, 0, 1, 0, 8'h00, 8'h00, 2'b00, 0, 8'h00, 1);
    vt[16] = mk(0, 0, 0, 0, 8'h10, 8'h00, 2'b01, 1, 8'h00, 1);
    vt[17] = mk(1, 0, 0, 1, 8'h00, 8'h00, 2'b00, 0, 8'h00, 1);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 8'h00);
    drive(1, 0, 0, 0, 0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("reset A_ack", {31'd0, A_ack}, 32'd0);
    check("reset B_ack", {31'd0, B_ack}, 32'd0);
    check("reset A_err", {30'd0, A_err}, 32'd0);
    check("reset B_out_data", {24'd0, B_out_data}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("first A_ack", {31'd0, A_ack}, 32'd1);
    check("first B_ack", {31'd0, B_ack}, 32'd1);

    for (int i = 0; i < 18; i++) begin
      run_txn(vt[i].pb, vt[i].rw, vt[i].hd, vt[i].rl, vt[i].addr, vt[i].data, e, d, lw);
      check($sformatf("row%0d err", i), {30'd0, e}, {30'd0, vt[i].err});
      check($sformatf("row%0d ack_low", i), lw, vt[i].low);
      if (vt[i].chk_data) check($sformatf("row%0d data", i), {24'd0, d}, {24'd0, vt[i].rdata});
    end

    // First collision: A wins, B completes one cycle later.
    drive(0, 1, 0, 0, 0, 8'h10);
    drive(1, 1, 0, 0, 0, 8'h20);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 8'h00);
    drive(1, 0, 0, 0, 0, 8'h00);
    check("col1 A_ack e0", {31'd0, A_ack}, 32'd0);
    @(posedge clk); #1;
    check("col1 A_ack e1", {31'd0, A_ack}, 32'd1);
    check("col1 B_ack e1", {31'd0, B_ack}, 32'd0);
    check("col1 A_data", {24'd0, A_out_data}, 32'h5A);
    @(posedge clk); #1;
    check("col1 B_ack e2", {31'd0, B_ack}, 32'd1);
    check("col1 B_data", {24'd0, B_out_data}, 32'h33);
    @(posedge clk); #1;

    // Second collision: B wins this time.
    drive(0, 1, 0, 0, 0, 8'h20);
    drive(1, 1, 0, 0, 0, 8'h10);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 8'h00);
    drive(1, 0, 0, 0, 0, 8'h00);
    @(posedge clk); #1;
    check("col2 B_ack e1", {31'd0, B_ack}, 32'd1);
    check("col2 A_ack e1", {31'd0, A_ack}, 32'd0);
    check("col2 B_data", {24'd0, B_out_data}, 32'h5A);
    @(posedge clk); #1;
    check("col2 A_ack e2", {31'd0, A_ack}, 32'd1);
    check("col2 A_data", {24'd0, A_out_data}, 32'h33);
    @(posedge clk); #1;

    // Reset on the grant edge of a write aborts it.
    drive(0, 1, 1, 0, 0, 8'h10);
    A_hold = 1'b0;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 8'hEE);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort A_ack", {31'd0, A_ack}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    run_txn(0, 0, 0, 0, 8'h10, 8'h00, e, d, lw);
    check("abort readback", {24'd0, d}, 32'h5A);

    // Lock held by A across a long idle gap.
    run_txn(0, 0, 1, 0, 8'h00, 8'h00, e, d, lw);
    check("tmo hold err", {30'd0, e}, 32'd0);
    repeat (9) @(posedge clk);
    #1;
    run_txn(1, 1, 0, 0, 8'h40, 8'h77, e, d, lw);
`ifdef CSM_LOCK_TIMEOUT_EN
    check("tmo B write err", {30'd0, e}, 32'd0);
    run_txn(0, 0, 0, 1, 8'h00, 8'h00, e, d, lw);
    check("tmo A release err", {30'd0, e}, 32'd2);
`else
    check("tmo B write err", {30'd0, e}, 32'd1);
    run_txn(0, 0, 0, 1, 8'h00, 8'h00, e, d, lw);
    check("tmo A release err", {30'd0, e}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
